// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU host-side blocks: FSM state encoding,
// datapath widths and the program-length acceptance rule.
package cpu_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMEM_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } state_e;

  // A load must carry at least one word and must fit in the instruction memory.
  function automatic logic len_ok(input logic [IMEM_ADDR_W-1:0] len, input int depth);
    return (len != '0) && ({16'h0000, len} <= 32'(depth));
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Host-side programming sequencer: streams instruction words into the CPU
// instruction memory at sequential addresses, then releases the CPU via start.
module imem_loader
  import cpu_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR  = 16'h0000,
  parameter int                     ADDR_STEP  = 1,
  parameter int                     IMEM_DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  input  logic [IMEM_ADDR_W-1:0] prog_len,
  input  logic                   abort,
  input  logic [INSTR_W-1:0]     word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic [INSTR_W-1:0]     InstrIn,
  output logic                   I_MEM_Write_Enable,
  output logic [IMEM_ADDR_W-1:0] MEM_Addr,
  output logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [IMEM_ADDR_W-1:0] STEP = 16'(ADDR_STEP);

  state_e                 state_q,     state_d;
  logic [IMEM_ADDR_W-1:0] len_q,       len_d;
  logic [IMEM_ADDR_W-1:0] cnt_q,       cnt_d;
  logic [IMEM_ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [INSTR_W-1:0]     instr_q,     instr_d;
  logic [IMEM_ADDR_W-1:0] addr_q,      addr_d;
  logic                   we_q,        we_d;
  logic                   start_q,     start_d;
  logic                   done_q,      done_d;
  logic                   err_q,       err_d;
  logic                   word_ready_q, word_ready_d;
  logic                   busy_q,      busy_d;

  logic accept;
  logic req_ok;

  assign accept = word_valid && word_ready_q;
  assign req_ok = len_ok(prog_len, IMEM_DEPTH);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    next_addr_d = next_addr_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    start_d     = start_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (abort) begin
      state_d = IDLE;
      start_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (load_req) begin
            if (req_ok) begin
              // Dropping start here stops the CPU before the first write lands.
              state_d     = LOAD;
              start_d     = 1'b0;
              len_d       = prog_len;
              cnt_d       = '0;
              next_addr_d = BASE_ADDR;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            instr_d     = word_in;
            addr_d      = next_addr_q;
            we_d        = 1'b1;
            next_addr_d = next_addr_q + STEP;
            cnt_d       = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == len_q) state_d = DRAIN;
          end
        end
        DRAIN: begin
          done_d  = 1'b1;
          start_d = 1'b1;
          state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    // Handshake and status flags are registered copies of the next state.
    word_ready_d = (state_d == LOAD);
    busy_d       = (state_d == LOAD) || (state_d == DRAIN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      next_addr_q  <= BASE_ADDR;
      instr_q      <= '0;
      addr_q       <= BASE_ADDR;
      we_q         <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      next_addr_q  <= next_addr_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign word_ready         = word_ready_q;
  assign InstrIn            = instr_q;
  assign I_MEM_Write_Enable = we_q;
  assign MEM_Addr           = addr_q;
  assign start              = start_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized loads compared against an
// expected write list built from base address, step and the word stream.
module tb_imem_loader;

  localparam logic [15:0] BASE  = 16'h0000;
  localparam int          STEP  = 1;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [15:0] prog_len = '0;
  logic        abort = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] InstrIn;
  logic        I_MEM_Write_Enable;
  logic [15:0] MEM_Addr;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(
    .BASE_ADDR (BASE),
    .ADDR_STEP (STEP),
    .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load_req          (load_req),
    .prog_len          (prog_len),
    .abort             (abort),
    .word_in           (word_in),
    .word_valid        (word_valid),
    .word_ready        (word_ready),
    .InstrIn           (InstrIn),
    .I_MEM_Write_Enable(I_MEM_Write_Enable),
    .MEM_Addr          (MEM_Addr),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed activity, sampled on the falling edge.
  logic [15:0] act_addr[$];
  logic [31:0] act_data[$];
  int          act_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          overlap_cnt = 0;
  int          hold_viol = 0;
  int          start_rise_cyc = -1;
  logic        prev_start = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (I_MEM_Write_Enable) begin
      act_addr.push_back(MEM_Addr);
      act_data.push_back(InstrIn);
      act_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (start && I_MEM_Write_Enable) overlap_cnt++;
    if (start && !prev_start) start_rise_cyc = cyc;
    if (rst && busy && !I_MEM_Write_Enable &&
        (InstrIn !== prev_instr || MEM_Addr !== prev_addr)) hold_viol++;
    prev_start = start;
    prev_instr = InstrIn;
    prev_addr  = MEM_Addr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    act_addr.delete();
    act_data.delete();
    act_cyc.delete();
    done_cnt       = 0;
    err_cnt        = 0;
    overlap_cnt    = 0;
    hold_viol      = 0;
    start_rise_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(word_ready), 64'd0);
    check({tag, "_instr"}, 64'(InstrIn), 64'd0);
    check({tag, "_we"},    64'(I_MEM_Write_Enable), 64'd0);
    check({tag, "_addr"},  64'(MEM_Addr), 64'(BASE));
    check({tag, "_start"}, 64'(start), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_err"},   64'(err), 64'd0);
  endtask

  // Runs one load of len words; abort_after >= 0 aborts once that many words
  // have been accepted, with a word offered on the abort edge.
  task automatic run_load(input int len, input bit gaps, input int abort_after, input string tag);
    logic [31:0] words[$];
    int          acc = 0;
    int          budget = 0;
    bit          hs;
    bit          aborted;
    int          exp_n;
    int          last;
    clear_logs();
    for (int k = 0; k < len; k++) words.push_back($urandom);
    load_req = 1'b1;
    prog_len = 16'(len);
    tick();
    load_req = 1'b0;
    check({tag, "_start_low"}, 64'(start), 64'd0);
    while (acc < len && acc != abort_after && budget < 4000) begin
      word_in    = words[acc];
      word_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      hs         = word_valid && word_ready;
      tick();
      if (hs) acc++;
      budget++;
    end
    check({tag, "_budget"}, 64'(budget < 4000), 64'd1);
    aborted = (abort_after >= 0) && (acc == abort_after);
    if (aborted) begin
      word_in    = $urandom;
      word_valid = 1'b1;
      abort      = 1'b1;
      tick();
      abort      = 1'b0;
    end
    word_valid = 1'b0;
    repeat (4) tick();

    exp_n = aborted ? abort_after : len;
    check({tag, "_nwrites"}, 64'(act_addr.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < act_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(act_addr[i]), 64'(16'(BASE + i * STEP)));
      check($sformatf("%s_data%0d", tag, i), 64'(act_data[i]), 64'(words[i]));
    end
    check({tag, "_done_cnt"}, 64'(done_cnt), aborted ? 64'd0 : 64'd1);
    check({tag, "_err_cnt"},  64'(err_cnt), 64'd0);
    check({tag, "_start"},    64'(start), aborted ? 64'd0 : 64'd1);
    check({tag, "_ready"},    64'(word_ready), 64'd0);
    check({tag, "_busy"},     64'(busy), 64'd0);
    check({tag, "_overlap"},  64'(overlap_cnt), 64'd0);
    check({tag, "_hold"},     64'(hold_viol), 64'd0);
    if (!aborted && !gaps && act_cyc.size() == len) begin
      last = act_cyc[len-1];
      check({tag, "_contig"},     64'(last - act_cyc[0]), 64'(len - 1));
      check({tag, "_start_rise"}, 64'(start_rise_cyc), 64'(last + 1));
    end
  endtask

  task automatic bad_req(input int len, input logic exp_start, input string tag);
    clear_logs();
    load_req = 1'b1;
    prog_len = 16'(len);
    tick();
    load_req   = 1'b0;
    word_valid = 1'b1;
    repeat (3) tick();
    word_valid = 1'b0;
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd1);
    check({tag, "_nwrites"}, 64'(act_addr.size()), 64'd0);
    check({tag, "_start"},   64'(start), 64'(exp_start));
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_ready"},   64'(word_ready), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b1;
    tick();

    run_load(4, 1'b0, -1, "l4");
    run_load(4, 1'b1, -1, "l4gap");
    bad_req(0, 1'b1, "bad0_run");

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_start", 64'(start), 64'd0);
    check("abort_run_busy",  64'(busy), 64'd0);

    bad_req(0, 1'b0, "bad0");
    bad_req(DEPTH + 1, 1'b0, "bad_over");

    for (int r = 0; r < 4; r++)
      run_load(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), -1,
               $sformatf("rnd%0d", r));

    run_load(5, 1'b1, 2, "abort2");
    run_load(3, 1'b0, -1, "after_abort");
    run_load(DEPTH, 1'b1, -1, "full");

    // Asynchronous reset in the middle of a load.
    clear_logs();
    load_req = 1'b1;
    prog_len = 16'd5;
    tick();
    load_req   = 1'b0;
    word_in    = $urandom;
    word_valid = 1'b1;
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    #3 rst = 1'b1;
    tick();
    check("arst_idle_ready", 64'(word_ready), 64'd0);
    check("arst_idle_busy",  64'(busy), 64'd0);
    clear_logs();
    repeat (3) tick();
    word_valid = 1'b0;
    tick();
    check("arst_no_writes", 64'(act_addr.size()), 64'd0);
    check("arst_no_done",   64'(done_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side programming sequencer for the multicycle CPU.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the CPU instruction memory at sequential addresses.
- Drives the CPU's InstrIn, I_MEM_Write_Enable and MEM_Addr inputs, then asserts start so the CPU runs the loaded program.
- Sits between the board/testbench program source and the CPU top.

Parameters:
- BASE_ADDR, 16'h0000, first instruction-memory address written.
- ADDR_STEP, 1, address increment per word (1 = word-addressed, 4 = byte-addressed).
- IMEM_DEPTH, 256, maximum words the instruction memory holds; larger loads are rejected.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- load_req  input  1  one-cycle request to begin a load; sampled in IDLE and RUN.
- prog_len  input  16  number of words to load; sampled with load_req.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- word_in  input  32  instruction word from the source.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  loader accepts word_in this cycle.
- InstrIn  output  32  instruction word to the CPU instruction memory.
- I_MEM_Write_Enable  output  1  instruction-memory write strobe.
- MEM_Addr  output  16  instruction-memory write address.
- start  output  1  CPU run enable (level).
- busy  output  1  high in LOAD or DRAIN.
- done  output  1  one-cycle pulse when the last word has been written.
- err  output  1  one-cycle pulse when a load request is rejected.

Behaviour:
- Reset (rst=0, async): state=IDLE; word_ready=0; InstrIn=0; I_MEM_Write_Enable=0; MEM_Addr=BASE_ADDR; start=0; busy=0; done=0; err=0; word counter=0.
- All outputs are registered. word_ready is a registered function of state.
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE:
  - load_req=1 with prog_len==0 or prog_len>IMEM_DEPTH: err=1 next cycle; remain in IDLE.
  - load_req=1 with a valid prog_len: latch prog_len; next_addr=BASE_ADDR; counter=0; go to LOAD.
- LOAD:
  - word_ready=1 and busy=1.
  - Handshake completes on a rising edge where word_valid && word_ready. On that edge:
    - InstrIn<=word_in.
    - MEM_Addr<=next_addr.
    - I_MEM_Write_Enable<=1.
    - next_addr+=ADDR_STEP (16-bit wrap; unreachable given the depth check).
    - counter+=1.
  - Result: a write is presented one cycle after acceptance and committed by the memory on the following edge.
  - On edges without a handshake, I_MEM_Write_Enable<=0. InstrIn and MEM_Addr hold their values.
  - Back-to-back valid words give a continuous write strobe, one word per cycle.
  - When the accepted word makes counter==prog_len: go to DRAIN, and word_ready drops on that same edge.
- DRAIN:
  - One cycle in which the final write is presented (WE=1).
  - Next edge: I_MEM_Write_Enable<=0, done<=1 (one-cycle pulse), start<=1, state=RUN.
- RUN:
  - start held at 1 and word_ready=0.
  - load_req with a valid prog_len: start<=0 on the same edge and go to LOAD. The CPU is stopped before any write.
  - load_req with an invalid prog_len: err pulse; stay in RUN with start unchanged.
- abort=1 in any state, highest priority after reset:
  - Next edge: state=IDLE; start=0; I_MEM_Write_Enable=0; word_ready=0; done and err not asserted.
  - A handshake on the abort edge is not counted and no write is issued.
- load_req in LOAD or DRAIN: ignored.
- word_valid outside LOAD: ignored, no handshake.
- start is never 1 while I_MEM_Write_Enable is 1.
- Reset mid-load: immediate return to reset values; partially written memory is not cleared.

Decomposition:
- Shared package (cpu_pkg): state encoding constants (IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, RUN=2'd3), INSTR_W=32, IMEM_ADDR_W=16.
- No sub-module. The address/word counter is inline. The design is a single FSM of about 150–200 lines.

Test Plan:
- Reset release, load_req with prog_len=4, words A0..A3 presented valid continuously → WE high for 4 consecutive cycles at addresses 0,1,2,3 with matching InstrIn; done pulses once; start=1 on the cycle after the last write; word_ready=0 afterwards.
- Same load with word_valid toggled 1,0,1,0 → exactly 4 writes at addresses 0..3; WE=0 in gap cycles; MEM_Addr and InstrIn held during gaps; no address skipped.
- load_req with prog_len=0, then with prog_len=IMEM_DEPTH+1 → err pulses once each; state stays IDLE; no WE; start=0.
- In RUN, load_req with prog_len=2 → start drops on the next edge before any WE; 2 writes at BASE_ADDR and BASE_ADDR+ADDR_STEP; start reasserts after done.
- abort asserted after 2 of 5 words → only 2 writes occur; next state IDLE; start=0; no done pulse; a following load of 3 words restarts at BASE_ADDR.
- rst driven low asynchronously mid-LOAD, between clock edges → all outputs at reset values immediately, with no clock edge needed; after release the loader is in IDLE with word_ready=0.
